// File: rtl/many_ports_arbiter_if.sv
// Requester- and unit-side bus of the many_ports_arbiter.
// The master modport is the arbiter; the slave modport is the requesters plus the shared unit.
interface many_ports_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int CTRL_W  = 4,
    parameter int RES_W   = 16,
    parameter int STAT_W  = 4
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ*CTRL_W-1:0] req_control;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [RES_W-1:0]          rsp_data;
    logic [STAT_W-1:0]         rsp_status;
    logic                      unit_enable;
    logic [DATA_W-1:0]         unit_data_in;
    logic [CTRL_W-1:0]         unit_control;
    logic                      unit_ready;
    logic                      unit_valid;
    logic [RES_W-1:0]          unit_data_out;
    logic [STAT_W-1:0]         unit_status;

    modport master (
        input  req_valid, req_data, req_control, rsp_ready,
        input  unit_ready, unit_valid, unit_data_out, unit_status,
        output req_ready, rsp_valid, rsp_data, rsp_status,
        output unit_enable, unit_data_in, unit_control
    );

    modport slave (
        output req_valid, req_data, req_control, rsp_ready,
        output unit_ready, unit_valid, unit_data_out, unit_status,
        input  req_ready, rsp_valid, rsp_data, rsp_status,
        input  unit_enable, unit_data_in, unit_control
    );
endinterface

// File: rtl/many_ports_arbiter.sv
// Round-robin arbiter sharing one multi-port unit among NUM_REQ requesters, one transaction in flight.
// Optional macro ARB_TIMEOUT_EN bounds the WAIT state and raises a sticky timeout_err.
module many_ports_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int CTRL_W  = 4,
    parameter int RES_W   = 16,
    parameter int STAT_W  = 4,
    parameter int TIMEOUT = 255,
    localparam int GW     = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    many_ports_arbiter_if.master bus,
    output logic [GW-1:0]        grant_id,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [1:0]           dbg_state_o
);
    // Requests: req_ready[i] is combinational and only in IDLE; a request transfers on
    // req_valid[i] & req_ready[i]. Unit: transfer on unit_enable & unit_ready, result on
    // unit_valid (WAIT only). Responses: transfer on rsp_valid[owner] & rsp_ready[owner].
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("many_ports_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
    end

    state_t             state_q;
    logic [GW-1:0]      grant_q;
    logic [GW-1:0]      last_grant_q;
    logic [DATA_W-1:0]  data_q;
    logic [CTRL_W-1:0]  ctrl_q;
    logic [RES_W-1:0]   rsp_data_q;
    logic [STAT_W-1:0]  rsp_status_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic               unit_enable_q;
    logic               busy_q;
    logic               win_found;
    logic [GW-1:0]      grant_d;

    // Search starts one past the last completed owner, so priority rotates only on completion.
    always_comb begin
        int            idx;
        logic [GW-1:0] cand;
        win_found = 1'b0;
        grant_d   = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx  = (int'(last_grant_q) + k) % NUM_REQ;
            cand = GW'(idx);
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                grant_d   = cand;
            end
        end
    end

    assign bus.req_ready = (state_q == IDLE && reset && win_found) ? (ONE << grant_d) : '0;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_status   = rsp_status_q;
    assign bus.unit_enable  = unit_enable_q;
    assign bus.unit_data_in = data_q;
    assign bus.unit_control = ctrl_q;
    assign grant_id         = grant_q;
    assign busy             = busy_q;
    assign dbg_state_o      = state_q;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] cnt_q;
    logic          timeout_q;
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            last_grant_q  <= GW'(NUM_REQ - 1);
            data_q        <= '0;
            ctrl_q        <= '0;
            rsp_data_q    <= '0;
            rsp_status_q  <= '0;
            rsp_valid_q   <= '0;
            unit_enable_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q         <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        data_q        <= bus.req_data[grant_d*DATA_W +: DATA_W];
                        ctrl_q        <= bus.req_control[grant_d*CTRL_W +: CTRL_W];
                        grant_q       <= grant_d;
                        unit_enable_q <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.unit_ready) begin
                        unit_enable_q <= 1'b0;
                        state_q       <= WAIT;
`ifdef ARB_TIMEOUT_EN
                        cnt_q         <= '0;
`endif
                    end
                end
                WAIT: begin
                    // A result arriving in the expiry cycle still wins over the timeout.
                    if (bus.unit_valid) begin
                        rsp_data_q   <= bus.unit_data_out;
                        rsp_status_q <= bus.unit_status;
                        rsp_valid_q  <= ONE << grant_q;
                        state_q      <= RESP;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        rsp_data_q   <= '0;
                        rsp_status_q <= '1;
                        rsp_valid_q  <= ONE << grant_q;
                        timeout_q    <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready[grant_q]) begin
                        rsp_valid_q  <= '0;
                        last_grant_q <= grant_q;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_many_ports_arbiter.sv
// Directed self-checking bench for many_ports_arbiter (4 requesters, 8/4/16/4 widths).
// Define ARB_TIMEOUT_EN to build the timeout scenario with TIMEOUT=8.
module tb_many_ports_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int CTRL_W  = 4;
  localparam int RES_W   = 16;
  localparam int STAT_W  = 4;
`ifdef ARB_TIMEOUT_EN
  localparam int TIMEOUT = 8;
`else
  localparam int TIMEOUT = 255;
`endif
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout_err;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         errors = 0;
  logic [RES_W-1:0] exp_q[$];

  many_ports_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CTRL_W(CTRL_W),
                          .RES_W(RES_W), .STAT_W(STAT_W)) bus ();

  many_ports_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CTRL_W(CTRL_W),
                       .RES_W(RES_W), .STAT_W(STAT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .grant_id(grant_id), .busy(busy),
    .timeout_err(timeout_err), .dbg_state_o(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    bus.req_valid = '0; bus.req_data = '0; bus.req_control = '0; bus.rsp_ready = '0;
    bus.unit_ready = 1'b0; bus.unit_valid = 1'b0; bus.unit_data_out = '0; bus.unit_status = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // scenarios
  task automatic test_reset();
    init_inputs();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, bus.unit_enable, bus.rsp_valid, bus.req_ready, grant_id, timeout_err, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=0", {busy, bus.unit_enable, bus.rsp_valid, bus.req_ready, grant_id, timeout_err, dbg_state});
    end
    checks++;
    if ({bus.rsp_data, bus.rsp_status, bus.unit_data_in, bus.unit_control} !== '0) begin
      errors++;
      $display("FAIL reset_data got=%h exp=0", {bus.rsp_data, bus.rsp_status, bus.unit_data_in, bus.unit_control});
    end
  endtask

  task automatic test_single();
    logic [RES_W-1:0] exp_d;
    bus.req_valid = 4'b0001; bus.req_data = 32'h0000_00A5; bus.req_control = 16'h0003;
    bus.unit_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_req_ready got=%b exp=0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    checks++;
    if ({bus.unit_enable, bus.unit_data_in, bus.unit_control, grant_id, busy} !== {1'b1, 8'hA5, 4'h3, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL single_issue got=%h exp=%h", {bus.unit_enable, bus.unit_data_in, bus.unit_control, grant_id, busy}, {1'b1, 8'hA5, 4'h3, 2'd0, 1'b1});
    end
    tick();
    checks++;
    if ({bus.unit_enable, dbg_state} !== {1'b0, S_WAIT}) begin errors++; $display("FAIL single_wait got=%b exp=010", {bus.unit_enable, dbg_state}); end
    tick();
    checks++;
    if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_early_rsp got=%b exp=0000", bus.rsp_valid); end
    bus.unit_valid = 1'b1; bus.unit_data_out = 16'h1234; bus.unit_status = 4'h5;
    exp_q.push_back(16'h1234);
    tick();
    bus.unit_valid = 1'b0;
    exp_d = exp_q.pop_front();
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_status} !== {4'b0001, exp_d, 4'h5}) begin
      errors++;
      $display("FAIL single_rsp got=%h exp=%h", {bus.rsp_valid, bus.rsp_data, bus.rsp_status}, {4'b0001, exp_d, 4'h5});
    end
    bus.rsp_ready = 4'b0001;
    tick();
    bus.rsp_ready = '0;
    checks++;
    if ({bus.rsp_valid, busy, bus.rsp_data} !== {4'b0000, 1'b0, 16'h1234}) begin
      errors++;
      $display("FAIL single_done got=%h exp=%h", {bus.rsp_valid, busy, bus.rsp_data}, {4'b0000, 1'b0, 16'h1234});
    end
  endtask

  task automatic test_round_robin();
    int order[5];
    logic [7:0] dat[4];
    logic [RES_W-1:0] exp_d;
    order = '{0, 1, 2, 3, 0};
    dat = '{8'h11, 8'h22, 8'h33, 8'h44};
    pulse_reset();
    bus.req_valid = 4'b1111; bus.rsp_ready = 4'b1111; bus.unit_ready = 1'b1;
    bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    #1;
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (bus.req_ready !== (4'b0001 << order[n])) begin
        errors++; $display("FAIL rr_req_ready[%0d] got=%b exp=%b", n, bus.req_ready, 4'b0001 << order[n]);
      end
      tick();
      checks++;
      if ({bus.req_ready, grant_id, bus.unit_data_in} !== {4'b0000, 2'(order[n]), dat[order[n]]}) begin
        errors++; $display("FAIL rr_grant[%0d] got=%h exp=%h", n, {bus.req_ready, grant_id, bus.unit_data_in}, {4'b0000, 2'(order[n]), dat[order[n]]});
      end
      tick();
      bus.unit_valid = 1'b1; bus.unit_data_out = 16'hC000 + 16'(n);
      exp_q.push_back(16'hC000 + 16'(n));
      tick();
      bus.unit_valid = 1'b0;
      exp_d = exp_q.pop_front();
      checks++;
      if ({bus.rsp_valid, bus.rsp_data} !== {4'b0001 << order[n], exp_d}) begin
        errors++; $display("FAIL rr_rsp[%0d] got=%h exp=%h", n, {bus.rsp_valid, bus.rsp_data}, {4'b0001 << order[n], exp_d});
      end
      tick();
    end
    bus.req_valid = '0; bus.rsp_ready = '0;
  endtask

  task automatic test_issue_stall();
    bus.req_valid = 4'b0100; bus.req_data = 32'h003C_0000; bus.req_control = 16'h0900;
    bus.unit_ready = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL stall_req_ready got=%b exp=0100", bus.req_ready); end
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({bus.unit_enable, bus.unit_data_in, bus.unit_control, bus.req_ready, busy} !== {1'b1, 8'h3C, 4'h9, 4'b0000, 1'b1}) begin
        errors++; $display("FAIL stall_issue[%0d] got=%h exp=%h", i, {bus.unit_enable, bus.unit_data_in, bus.unit_control, bus.req_ready, busy}, {1'b1, 8'h3C, 4'h9, 4'b0000, 1'b1});
      end
      if (i == 5) bus.unit_ready = 1'b1;
      tick();
    end
    checks++;
    if ({bus.unit_enable, dbg_state} !== {1'b0, S_WAIT}) begin errors++; $display("FAIL stall_wait got=%b exp=010", {bus.unit_enable, dbg_state}); end
    bus.unit_valid = 1'b1; bus.unit_data_out = 16'hBEEF; bus.unit_status = 4'hA;
    tick();
    bus.unit_valid = 1'b0; bus.req_valid = '0;
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_status} !== {4'b0100, 16'hBEEF, 4'hA}) begin
      errors++; $display("FAIL stall_rsp got=%h exp=%h", {bus.rsp_valid, bus.rsp_data, bus.rsp_status}, {4'b0100, 16'hBEEF, 4'hA});
    end
    bus.rsp_ready = 4'b0100;
    tick();
    bus.rsp_ready = '0;
  endtask

  task automatic test_rsp_backpressure();
    bus.req_valid = 4'b1011; bus.req_data = '0; bus.req_control = '0; bus.unit_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL bp_req_ready got=%b exp=1000", bus.req_ready); end
    tick(); tick();
    bus.unit_valid = 1'b1; bus.unit_data_out = 16'hDA7A; bus.unit_status = 4'h6;
    tick();
    bus.unit_valid = 1'b0; bus.rsp_ready = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_status, bus.req_ready, grant_id} !== {4'b1000, 16'hDA7A, 4'h6, 4'b0000, 2'd3}) begin
        errors++; $display("FAIL bp_hold[%0d] got=%h exp=%h", i, {bus.rsp_valid, bus.rsp_data, bus.rsp_status, bus.req_ready, grant_id}, {4'b1000, 16'hDA7A, 4'h6, 4'b0000, 2'd3});
      end
      if (i == 3) bus.rsp_ready = 4'b1111;
      tick();
    end
    checks++;
    if ({bus.rsp_valid, bus.req_ready} !== {4'b0000, 4'b0001}) begin
      errors++; $display("FAIL bp_release got=%b exp=00000001", {bus.rsp_valid, bus.req_ready});
    end
    bus.req_valid = '0; bus.rsp_ready = '0;
  endtask

  task automatic test_reset_mid();
    bus.req_valid = 4'b0010; bus.unit_ready = 1'b1;
    tick();
    bus.req_valid = '0;
    tick();
    checks++;
    if (dbg_state !== S_WAIT) begin errors++; $display("FAIL mid_in_wait got=%0d exp=2", dbg_state); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus.unit_valid = 1'b1; bus.unit_data_out = 16'h5555; bus.unit_status = 4'h7;
    #1;
    checks++;
    if ({busy, bus.unit_enable, bus.rsp_valid, bus.req_ready, grant_id, timeout_err, dbg_state, bus.rsp_data, bus.rsp_status, bus.unit_data_in} !== '0) begin
      errors++; $display("FAIL mid_reset got=%h exp=0", {busy, bus.unit_enable, bus.rsp_valid, bus.req_ready, grant_id, timeout_err, dbg_state, bus.rsp_data, bus.rsp_status, bus.unit_data_in});
    end
    tick();
    bus.unit_valid = 1'b0;
    checks++;
    if ({dbg_state, bus.rsp_valid, bus.rsp_data} !== '0) begin
      errors++; $display("FAIL mid_ignore_valid got=%h exp=0", {dbg_state, bus.rsp_valid, bus.rsp_data});
    end
    bus.req_valid = 4'b1111;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_winner got=%b exp=0001", bus.req_ready); end
    bus.req_valid = '0;
    #1;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    bus.req_valid = 4'b0001; bus.unit_ready = 1'b1;
    tick();
    bus.req_valid = '0;
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({dbg_state, bus.rsp_valid, timeout_err} !== {S_WAIT, 4'b0000, 1'b0}) begin
        errors++; $display("FAIL to_wait[%0d] got=%b exp=1000000", i, {dbg_state, bus.rsp_valid, timeout_err});
      end
      tick();
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_status, timeout_err} !== {4'b0001, 16'h0000, 4'hF, 1'b1}) begin
      errors++; $display("FAIL to_expire got=%h exp=%h", {bus.rsp_valid, bus.rsp_data, bus.rsp_status, timeout_err}, {4'b0001, 16'h0000, 4'hF, 1'b1});
    end
    bus.rsp_ready = 4'b0001;
    tick();
    bus.rsp_ready = '0;
    checks++;
    if ({dbg_state, timeout_err} !== {S_IDLE, 1'b1}) begin errors++; $display("FAIL to_sticky got=%b exp=001", {dbg_state, timeout_err}); end
    pulse_reset();
    #1;
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear got=%b exp=0", timeout_err); end
  endtask
`else
  task automatic test_timeout();
    bus.req_valid = 4'b0001; bus.unit_ready = 1'b1;
    tick();
    bus.req_valid = '0;
    repeat (20) tick();
    checks++;
    if ({dbg_state, bus.rsp_valid, timeout_err} !== {S_WAIT, 4'b0000, 1'b0}) begin
      errors++; $display("FAIL nto_unbounded got=%b exp=1000000", {dbg_state, bus.rsp_valid, timeout_err});
    end
    bus.unit_valid = 1'b1; bus.unit_data_out = 16'h0F0F; bus.unit_status = 4'h1;
    tick();
    bus.unit_valid = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_status} !== {4'b0001, 16'h0F0F, 4'h1}) begin
      errors++; $display("FAIL nto_rsp got=%h exp=%h", {bus.rsp_valid, bus.rsp_data, bus.rsp_status}, {4'b0001, 16'h0F0F, 4'h1});
    end
    bus.rsp_ready = 4'b0001;
    tick();
    bus.rsp_ready = '0;
  endtask
`endif

  // sequence and final report
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_issue_stall();
    test_rsp_backpressure();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
